serial_sub16: RTL

//  Bit-serial subtractor computing D = A - B - Bin over WIDTH clocks, LSB first.
//  It is the inverse-operation companion to the parallel ripple-carry adder datapath.

---
 rtl/sub_pkg.sv | 10 +
 rtl/fsub1.sv | 15 +
 rtl/serial_sub16.sv | 99 +++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
// Imported by the subtractor top level.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

  localparam int SUB_W_DEF = 16;

endpackage

// File: rtl/fsub1.sv
// One-bit full subtractor: d = a - b - br_in, with borrow out.
// Purely combinational, zero latency.
// No handshake; the caller sequences it one bit per clock.
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Latency: done pulses WIDTH edges after the accept edge.
// strt is only honoured in IDLE/DONE; it is ignored while busy.
module serial_sub16
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovfl,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             bit_d;
  logic             bit_br;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_ext;

  // The single shared cell works on the current LSBs and the running borrow.
  fsub1 u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .br_in  (brw),
    .d      (bit_d),
    .br_out (bit_br)
  );

  assign accept   = strt && (state != SHIFT);
  assign last_bit = (state == SHIFT) && (cnt == LAST);
  // New bit enters at the MSB; after the final bit this is the full result.
  assign res_ext  = {bit_d, res_sr};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // FSM, operand/result shifting and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      state  <= SHIFT;
      a_sr   <= A;
      b_sr   <= B;
      brw    <= Bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_ext[WIDTH-1:1];
      brw    <= bit_br;
      if (last_bit) begin
        state <= DONE;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      state <= IDLE;
    end
  end

  // Result registers load on the final bit and hold until the next completion.
  // On the last bit a_sr[0]/b_sr[0] are the sampled operand MSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D    <= '0;
      Bout <= 1'b0;
      ovfl <= 1'b0;
    end else if (last_bit) begin
      D    <= res_ext;
      Bout <= bit_br;
      ovfl <= (a_sr[0] ^ b_sr[0]) & (bit_d ^ a_sr[0]);
    end
  end

endmodule
